axi_lite_cfg_master: RTL and testbench

- AXI4-Lite master that sits directly upstream of the JPEG IP's S00_AXI register slave and drives its configuration and status registers.
- Accepts simple write/read commands over a valid/ready command port.
- Runs each command as one AXI4-Lite transaction, with a single transaction outstanding at a time.
- Returns the response code and any read data on a valid/ready response port.

---
 rtl/axi_lite_cfg_pkg.sv | 30 +++
 rtl/axi_lite_cfg_rsp_reg.sv | 41 ++++
 rtl/axi_lite_cfg_master.sv | 260 ++++++++++++++++++++++++++
 tb/tb_axi_lite_cfg_master.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_cfg_pkg.sv
// Shared types and constants for the AXI4-Lite configuration master.
package axi_lite_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        WR_B  = 3'd2,
        RD_A  = 3'd3,
        RD_D  = 3'd4,
        VFY_A = 3'd5,
        VFY_D = 3'd6,
        RESP  = 3'd7
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Expand 4 byte strobes into a 32-bit byte-lane mask.
    function automatic logic [31:0] wstrb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        mask = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/axi_lite_cfg_rsp_reg.sv
// Response holding register: loads once per transaction and keeps rsp_* stable until consumed.
module axi_lite_cfg_rsp_reg #(
    parameter int DW = 32
) (
    input  logic          ACLK,
    input  logic          ARESET,
    input  logic          load,
    input  logic          ld_write,
    input  logic [1:0]    ld_resp,
    input  logic [DW-1:0] ld_rdata,
    input  logic          ld_mismatch,
    input  logic          rsp_ready,
    output logic          rsp_valid,
    output logic          rsp_write,
    output logic [1:0]    rsp_resp,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_mismatch
);

    // Load on request, clear valid on handshake, otherwise hold.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rsp_valid    <= 1'b0;
            rsp_write    <= 1'b0;
            rsp_resp     <= 2'b00;
            rsp_rdata    <= {DW{1'b0}};
            rsp_mismatch <= 1'b0;
        end else if (load) begin
            rsp_valid    <= 1'b1;
            rsp_write    <= ld_write;
            rsp_resp     <= ld_resp;
            rsp_rdata    <= ld_rdata;
            rsp_mismatch <= ld_mismatch;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid    <= 1'b0;
        end else begin
            rsp_valid    <= rsp_valid;
        end
    end

endmodule

// File: rtl/axi_lite_cfg_master.sv
// AXI4-Lite configuration master: each command runs as one AXI4-Lite transaction, one outstanding.
// Define AXI_LITE_RDBK_VERIFY_EN to follow every write with a verifying read-back.
module axi_lite_cfg_master
    import axi_lite_cfg_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_write,
    output logic [1:0]                      rsp_resp,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic                            rsp_mismatch,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;

    state_t        state_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;
    logic [SW-1:0] wstrb_r;
    logic          write_r;
    logic          cmd_ready_r;
    logic          awvalid_r;
    logic          wvalid_r;
    logic          bready_r;
    logic          arvalid_r;
    logic          rready_r;
    logic          aw_done_r;
    logic          w_done_r;
    logic [1:0]    resp_r;
    logic [DW-1:0] rdata_r;
    logic          rsp_load_r;
    logic          rsp_sent_r;
    logic          aw_hs_s;
    logic          w_hs_s;
    logic          rsp_valid_s;
    logic          ld_mismatch_s;
`ifdef AXI_LITE_RDBK_VERIFY_EN
    logic          mismatch_r;
`endif

    assign aw_hs_s = awvalid_r && M_AXI_AWREADY;
    assign w_hs_s  = wvalid_r && M_AXI_WREADY;

    // Transaction sequencer; every AXI and command-side control output is a register here.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r     <= IDLE;
            addr_r      <= {AW{1'b0}};
            wdata_r     <= {DW{1'b0}};
            wstrb_r     <= {SW{1'b0}};
            write_r     <= 1'b0;
            cmd_ready_r <= 1'b0;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            bready_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            resp_r      <= RESP_OKAY;
            rdata_r     <= {DW{1'b0}};
            rsp_load_r  <= 1'b0;
            rsp_sent_r  <= 1'b0;
`ifdef AXI_LITE_RDBK_VERIFY_EN
            mismatch_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid && cmd_ready_r) begin
                        cmd_ready_r <= 1'b0;
                        write_r     <= cmd_write;
                        addr_r      <= cmd_addr;
                        wdata_r     <= cmd_wdata;
                        wstrb_r     <= cmd_wstrb;
                        resp_r      <= RESP_OKAY;
                        rdata_r     <= {DW{1'b0}};
`ifdef AXI_LITE_RDBK_VERIFY_EN
                        mismatch_r  <= 1'b0;
`endif
                        if (cmd_write) begin
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            aw_done_r <= 1'b0;
                            w_done_r  <= 1'b0;
                            state_r   <= WR;
                        end else begin
                            arvalid_r <= 1'b1;
                            state_r   <= RD_A;
                        end
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                WR: begin
                    // AW and W retire independently; either order or the same cycle is fine.
                    if (aw_hs_s) begin
                        awvalid_r <= 1'b0;
                    end
                    if (w_hs_s) begin
                        wvalid_r <= 1'b0;
                    end
                    if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        bready_r  <= 1'b1;
                        state_r   <= WR_B;
                    end else begin
                        aw_done_r <= aw_done_r || aw_hs_s;
                        w_done_r  <= w_done_r || w_hs_s;
                    end
                end
                WR_B: begin
                    if (M_AXI_BVALID && bready_r) begin
                        bready_r <= 1'b0;
                        resp_r   <= M_AXI_BRESP;
`ifdef AXI_LITE_RDBK_VERIFY_EN
                        if (M_AXI_BRESP == RESP_OKAY) begin
                            arvalid_r <= 1'b1;
                            state_r   <= VFY_A;
                        end else begin
                            state_r   <= RESP;
                        end
`else
                        state_r  <= RESP;
`endif
                    end
                end
                RD_A: begin
                    if (arvalid_r && M_AXI_ARREADY) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= RD_D;
                    end
                end
                RD_D: begin
                    if (M_AXI_RVALID && rready_r) begin
                        rready_r <= 1'b0;
                        rdata_r  <= M_AXI_RDATA;
                        resp_r   <= M_AXI_RRESP;
                        state_r  <= RESP;
                    end
                end
`ifdef AXI_LITE_RDBK_VERIFY_EN
                VFY_A: begin
                    if (arvalid_r && M_AXI_ARREADY) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= VFY_D;
                    end
                end
                VFY_D: begin
                    // Only reached with BRESP=OKAY, so RRESP alone decides the response code.
                    if (M_AXI_RVALID && rready_r) begin
                        rready_r   <= 1'b0;
                        rdata_r    <= M_AXI_RDATA;
                        resp_r     <= M_AXI_RRESP;
                        mismatch_r <= (((M_AXI_RDATA ^ wdata_r) & wstrb_to_mask(wstrb_r)) != {DW{1'b0}})
                                      && (M_AXI_RRESP == RESP_OKAY);
                        state_r    <= RESP;
                    end
                end
`endif
                RESP: begin
                    if (!rsp_sent_r) begin
                        rsp_load_r <= 1'b1;
                        rsp_sent_r <= 1'b1;
                    end else begin
                        rsp_load_r <= 1'b0;
                        if (rsp_valid_s && rsp_ready) begin
                            rsp_sent_r  <= 1'b0;
                            cmd_ready_r <= 1'b1;
                            state_r     <= IDLE;
                        end
                    end
                end
                default: begin
                    awvalid_r   <= 1'b0;
                    wvalid_r    <= 1'b0;
                    bready_r    <= 1'b0;
                    arvalid_r   <= 1'b0;
                    rready_r    <= 1'b0;
                    rsp_load_r  <= 1'b0;
                    rsp_sent_r  <= 1'b0;
                    cmd_ready_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

`ifdef AXI_LITE_RDBK_VERIFY_EN
    assign ld_mismatch_s = mismatch_r;
`else
    assign ld_mismatch_s = 1'b0;
`endif

    axi_lite_cfg_rsp_reg #(.DW(DW)) u_rsp_reg (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .load         (rsp_load_r),
        .ld_write     (write_r),
        .ld_resp      (resp_r),
        .ld_rdata     (rdata_r),
        .ld_mismatch  (ld_mismatch_s),
        .rsp_ready    (rsp_ready),
        .rsp_valid    (rsp_valid_s),
        .rsp_write    (rsp_write),
        .rsp_resp     (rsp_resp),
        .rsp_rdata    (rsp_rdata),
        .rsp_mismatch (rsp_mismatch)
    );

    assign rsp_valid     = rsp_valid_s;
    assign cmd_ready     = cmd_ready_r;
    assign M_AXI_AWADDR  = addr_r;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_r;
    assign M_AXI_WDATA   = wdata_r;
    assign M_AXI_WSTRB   = wstrb_r;
    assign M_AXI_WVALID  = wvalid_r;
    assign M_AXI_BREADY  = bready_r;
    assign M_AXI_ARADDR  = addr_r;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_r;
    assign M_AXI_RREADY  = rready_r;

endmodule

// File: tb/tb_axi_lite_cfg_master.sv
// Self-checking bench for axi_lite_cfg_master with a configurable AXI4-Lite slave model.
// Also covers the read-back feature when AXI_LITE_RDBK_VERIFY_EN is defined.
module tb_axi_lite_cfg_master;

`ifdef AXI_LITE_RDBK_VERIFY_EN
    localparam bit VFY    = 1'b1;
    localparam int WR_LAT = 6;
`else
    localparam bit VFY    = 1'b0;
    localparam int WR_LAT = 4;
`endif

    logic tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    logic        ARESET, cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_mismatch;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_rdata;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    axi_lite_cfg_master dut (
        .ACLK(tb_ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata), .rsp_mismatch(rsp_mismatch),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    // ---------------- slave model ----------------
    int          aw_dly, w_dly;
    logic [1:0]  bresp_cfg, rresp_cfg;
    logic        rd_ovr_en;
    logic [31:0] rd_ovr;
    int          aw_wait = 0, w_wait = 0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    logic        aw_got = 1'b0, w_got = 1'b0;
    logic [31:0] aw_addr_q = 32'h0, w_data_q = 32'h0, last_awaddr = 32'h0, last_araddr = 32'h0;
    logic [3:0]  w_strb_q = 4'h0;
    logic [31:0] mem [0:15];
    logic        aw_hs, w_hs, ar_hs;
    logic [31:0] eff_awaddr, eff_wdata;
    logic [3:0]  eff_wstrb;

    assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_wait >= aw_dly);
    assign M_AXI_WREADY  = M_AXI_WVALID && (w_wait >= w_dly);
    assign M_AXI_ARREADY = M_AXI_ARVALID;
    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
    assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
    assign eff_awaddr = aw_hs ? M_AXI_AWADDR : aw_addr_q;
    assign eff_wdata  = w_hs ? M_AXI_WDATA : w_data_q;
    assign eff_wstrb  = w_hs ? M_AXI_WSTRB : w_strb_q;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    always @(posedge tb_ACLK) begin
        if (ARESET) begin
            aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
            M_AXI_RVALID <= 1'b0; M_AXI_RRESP <= 2'b00; M_AXI_RDATA <= 32'h0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        end else begin
            if (aw_hs) begin
                aw_wait <= 0; aw_cnt <= aw_cnt + 1; aw_got <= 1'b1;
                aw_addr_q <= M_AXI_AWADDR; last_awaddr <= M_AXI_AWADDR;
            end else if (M_AXI_AWVALID) aw_wait <= aw_wait + 1;
            if (w_hs) begin
                w_wait <= 0; w_cnt <= w_cnt + 1; w_got <= 1'b1;
                w_data_q <= M_AXI_WDATA; w_strb_q <= M_AXI_WSTRB;
            end else if (M_AXI_WVALID) w_wait <= w_wait + 1;
            if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                aw_got <= 1'b0; w_got <= 1'b0;
                M_AXI_BVALID <= 1'b1; M_AXI_BRESP <= bresp_cfg;
                if (bresp_cfg == 2'b00)
                    mem[eff_awaddr[5:2]] <= merge(mem[eff_awaddr[5:2]], eff_wdata, eff_wstrb);
            end
            if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
            if (ar_hs) begin
                ar_cnt <= ar_cnt + 1; last_araddr <= M_AXI_ARADDR;
                M_AXI_RVALID <= 1'b1; M_AXI_RRESP <= rresp_cfg;
                M_AXI_RDATA <= rd_ovr_en ? rd_ovr : mem[M_AXI_ARADDR[5:2]];
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    logic [1:0]  o_resp;
    logic [31:0] o_rdata;
    logic        o_write, o_mism;
    int          o_lat;

    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int hold);
        int n;
        @(negedge tb_ACLK);
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin @(negedge tb_ACLK); n++; end
        chk("cmd_accept_in_time", 32'(n < 100), 32'h1);
        @(negedge tb_ACLK);
        cmd_valid = 1'b0;
        o_lat = 0;
        while (rsp_valid !== 1'b1 && o_lat < 200) begin @(negedge tb_ACLK); o_lat++; end
        chk("rsp_in_time", 32'(o_lat < 200), 32'h1);
        o_resp = rsp_resp; o_rdata = rsp_rdata; o_write = rsp_write; o_mism = rsp_mismatch;
        for (int i = 0; i < hold; i++) begin
            @(negedge tb_ACLK);
            chk("hold_rsp_valid", rsp_valid, 32'h1);
            chk("hold_rsp_rdata", rsp_rdata, o_rdata);
            chk("hold_rsp_resp", rsp_resp, o_resp);
            chk("hold_cmd_ready_low", cmd_ready, 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge tb_ACLK);
        rsp_ready = 1'b0;
        chk("rsp_valid_after_hs", rsp_valid, 32'h0);
        chk("cmd_ready_after_hs", cmd_ready, 32'h1);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        logic [1:0]  bresp;
        logic [1:0]  rresp;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic [31:0] exp_vrdata;
        logic        chk_lat;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int aw0, w0, ar0, n;
        logic [31:0] exp_rd;
        ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
        cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
        aw_dly = 0; w_dly = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00;
        rd_ovr_en = 1'b0; rd_ovr = 32'h0;

        //          wr    addr          wdata         strb  aw w  bresp  rresp  exp_resp rdata         vrdata        lat
        vecs[0] = '{1'b1, 32'h0000_0000, 32'h0101_FFFF, 4'hF, 0, 0, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0101_FFFF, 1'b1};
        vecs[1] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, 0, 2'b00, 2'b00, 2'b00, 32'h0101_FFFF, 32'h0,         1'b1};
        vecs[2] = '{1'b1, 32'h0000_0008, 32'h1234_5678, 4'hF, 3, 0, 2'b00, 2'b00, 2'b00, 32'h0,         32'h1234_5678, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_0008, 32'h9abc_def0, 4'hF, 0, 3, 2'b00, 2'b00, 2'b00, 32'h0,         32'h9abc_def0, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0008, 32'h0bad_f00d, 4'hF, 2, 2, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0bad_f00d, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 0, 0, 2'b00, 2'b00, 2'b00, 32'h0bad_f00d, 32'h0,         1'b1};
        vecs[6] = '{1'b1, 32'h0000_000C, 32'h55aa_55aa, 4'hF, 0, 0, 2'b10, 2'b00, 2'b10, 32'h0,         32'h0,         1'b1};
        vecs[7] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, 0, 2'b00, 2'b11, 2'b11, 32'h0101_FFFF, 32'h0,         1'b1};
        vecs[8] = '{1'b1, 32'h0000_0001, 32'hA5A5_A5A5, 4'h1, 0, 0, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0101_FFA5, 1'b1};
        vecs[9] = '{1'b0, 32'h0000_0003, 32'h0,         4'h0, 0, 0, 2'b00, 2'b00, 2'b00, 32'h0101_FFA5, 32'h0,         1'b1};

        repeat (3) @(negedge tb_ACLK);
        chk("reset_cmd_ready", cmd_ready, 32'h0);
        chk("reset_awvalid", M_AXI_AWVALID, 32'h0);
        chk("reset_wvalid", M_AXI_WVALID, 32'h0);
        chk("reset_arvalid", M_AXI_ARVALID, 32'h0);
        chk("reset_bready", M_AXI_BREADY, 32'h0);
        chk("reset_rready", M_AXI_RREADY, 32'h0);
        chk("reset_rsp_valid", rsp_valid, 32'h0);
        chk("reset_rsp_fields", {rsp_write, rsp_mismatch, rsp_resp}, 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_awaddr", M_AXI_AWADDR, 32'h0);
        ARESET = 1'b0;
        @(negedge tb_ACLK);
        chk("idle_cmd_ready", cmd_ready, 32'h1);

        for (int k = 0; k < NV; k++) begin
            aw_dly = vecs[k].aw_dly; w_dly = vecs[k].w_dly;
            bresp_cfg = vecs[k].bresp; rresp_cfg = vecs[k].rresp;
            aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt;
            run_txn(vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].strb, 0);
            exp_rd = vecs[k].wr ? (VFY ? vecs[k].exp_vrdata : 32'h0) : vecs[k].exp_rdata;
            chk($sformatf("v%0d_resp", k), o_resp, vecs[k].exp_resp);
            chk($sformatf("v%0d_rdata", k), o_rdata, exp_rd);
            chk($sformatf("v%0d_write", k), o_write, vecs[k].wr);
            chk($sformatf("v%0d_mismatch", k), o_mism, 32'h0);
            if (vecs[k].chk_lat)
                chk($sformatf("v%0d_latency", k), o_lat,
                    (vecs[k].wr && vecs[k].bresp == 2'b00) ? WR_LAT : 4);
            chk($sformatf("v%0d_aw_count", k), aw_cnt - aw0, vecs[k].wr ? 1 : 0);
            chk($sformatf("v%0d_w_count", k), w_cnt - w0, vecs[k].wr ? 1 : 0);
            chk($sformatf("v%0d_ar_count", k), ar_cnt - ar0,
                vecs[k].wr ? ((VFY && vecs[k].bresp == 2'b00) ? 1 : 0) : 1);
            if (vecs[k].wr) chk($sformatf("v%0d_awaddr", k), last_awaddr, vecs[k].addr);
            else            chk($sformatf("v%0d_araddr", k), last_araddr, vecs[k].addr);
            chk($sformatf("v%0d_prot", k), {M_AXI_AWPROT, M_AXI_ARPROT}, 32'h0);
        end
        bresp_cfg = 2'b00; rresp_cfg = 2'b00; aw_dly = 0; w_dly = 0;

        // Response backpressure: rsp_ready low for 10 cycles.
        run_txn(1'b1, 32'h0000_0010, 32'h0000_0042, 4'hF, 10);
        chk("bp_resp", o_resp, 32'h0);
        chk("bp_write", o_write, 32'h1);
        run_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0);
        chk("bp_readback", o_rdata, 32'h0000_0042);

        // Reset while AWVALID is pending.
        aw_dly = 20; w_dly = 20;
        @(negedge tb_ACLK);
        cmd_write = 1'b1; cmd_addr = 32'h0000_0004; cmd_wdata = 32'h1111_1111;
        cmd_wstrb = 4'hF; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin @(negedge tb_ACLK); n++; end
        @(negedge tb_ACLK);
        cmd_valid = 1'b0;
        n = 0;
        while (M_AXI_AWVALID !== 1'b1 && n < 20) begin @(negedge tb_ACLK); n++; end
        chk("midrst_awvalid_seen", M_AXI_AWVALID, 32'h1);
        ARESET = 1'b1;
        @(negedge tb_ACLK);
        ARESET = 1'b0;
        chk("midrst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 32'h0);
        chk("midrst_readies", {M_AXI_BREADY, M_AXI_RREADY}, 32'h0);
        chk("midrst_rsp_valid", rsp_valid, 32'h0);
        aw_dly = 0; w_dly = 0;
        @(negedge tb_ACLK);
        chk("midrst_idle_cmd_ready", cmd_ready, 32'h1);
        chk("midrst_no_rsp", rsp_valid, 32'h0);
        run_txn(1'b1, 32'h0000_0004, 32'habcd_0001, 4'hF, 0);
        chk("midrst_wr_resp", o_resp, 32'h0);
        chk("midrst_wr_latency", o_lat, WR_LAT);
        run_txn(1'b0, 32'h0000_0004, 32'h0, 4'h0, 0);
        chk("midrst_rd_data", o_rdata, 32'habcd_0001);

`ifdef AXI_LITE_RDBK_VERIFY_EN
        // Read-back compare only looks at strobed bytes.
        rd_ovr_en = 1'b1; rd_ovr = 32'hbeef_0011;
        run_txn(1'b1, 32'h0000_0014, 32'hdead_0011, 4'h3, 0);
        chk("vfy_match_mismatch", o_mism, 32'h0);
        chk("vfy_match_rdata", o_rdata, 32'hbeef_0011);
        chk("vfy_match_latency", o_lat, 32'd6);
        rd_ovr = 32'hbeef_0012;
        run_txn(1'b1, 32'h0000_0014, 32'hdead_0011, 4'h3, 0);
        chk("vfy_diff_mismatch", o_mism, 32'h1);
        chk("vfy_diff_resp", o_resp, 32'h0);
        rd_ovr_en = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
